spi_cmd_regfile: RTL and testbench
==================================

Name: spi_cmd_regfile

Overview:
- Downstream stage of the SPI slave byte engine.
- Consumes received bytes framed by chip-select and decodes a simple command protocol: byte 0 is the command, the following bytes are data.
- Holds a small register file that the SPI master can read and write with address auto-increment.
- Supplies the next byte to shift out on miso, and drives the board LED register and an error counter.

Parameters:
- NUM_REGS, 16, number of 8-bit registers; must be a power of 2, maximum 128.
- ADDR_W, 4, equals log2(NUM_REGS).
- ID_VALUE, 8'hA5, constant returned at address NUM_REGS-1, which is read-only.

Ports:
- clk  in  1  system clock (internal oscillator, 12.09 MHz).
- rst_n  in  1  asynchronous active-low reset.
- frame_active  in  1  synchronized chip-select; high while cs is asserted (low on the pin).
- rx_valid  in  1  one-cycle pulse: rx_data holds a complete received byte.
- rx_data  in  8  received MOSI byte, valid only when rx_valid=1.
- tx_data  out  8  byte the slave loads at the start of its next byte time.
- led_out  out  8  contents of register 0, active-high; the top level inverts it for the pins.
- busy  out  1  high whenever state is not IDLE.
- err_cnt  out  8  saturating count of protocol errors.

Behaviour:
- Reset (asynchronous): state=IDLE, all registers=0, addr=0, tx_data=8'h00, led_out=8'h00, err_cnt=0, busy=0.
- Reset asserted mid-frame aborts the frame immediately. After release the block waits in IDLE until it sees frame_active low and then high again; the rest of an interrupted frame is never decoded.
- IDLE:
  - frame_active rising (0 in the previous cycle, 1 now) -> CMD.
  - rx_valid in IDLE is ignored.
- CMD: on rx_valid, cmd = rx_data.
  - cmd[6:0] >= NUM_REGS -> DISCARD; err_cnt += 1.
  - cmd[7]=0 -> WRITE, addr = cmd[ADDR_W-1:0].
  - cmd[7]=1 -> READ, addr = cmd[ADDR_W-1:0]; tx_data = reg[addr] on the same edge (1-cycle latency after rx_valid).
- WRITE: each rx_valid writes reg[addr] <= rx_data, then addr <= addr+1, wrapping modulo NUM_REGS.
  - A write to address NUM_REGS-1 is silently dropped (no error), but addr still advances.
  - tx_data stays 8'h00.
- READ: each rx_valid (the master's dummy byte) advances addr <= addr+1 with wrap, and tx_data <= value at the new addr on the same edge.
  - Reads of address NUM_REGS-1 return ID_VALUE.
  - The first data byte the master clocks in is reg[cmd addr]; this requires the slave to sample tx_data at least 1 clk after rx_valid.
- DISCARD: all rx_valid ignored; tx_data = 8'hFF.
- frame_active low in any non-IDLE state -> IDLE on the next edge. Registers and err_cnt are retained; tx_data returns to 8'h00.
- Simultaneous rx_valid and frame_active falling: the byte is processed first (write, or address advance), and the next state is IDLE.
- Frame ending in CMD with no byte received: not an error.
- led_out is a continuous copy of reg[0]; it changes on the same edge as the write.
- err_cnt saturates at 8'hFF.
- Register file is plain flops, NUM_REGS x 8 bits, no RAM inference required.

Decomposition:
- Shared package (spi_pkg):
  - state encoding: IDLE, CMD, WRITE, READ, DISCARD
  - CMD_RD_BIT = 7
  - TX_IDLE = 8'h00
  - TX_ERR = 8'hFF
- One natural sub-module, spi_regfile: the flop array with write enable, the read-only top-address mux, and the reg0 tap. The FSM, address counter and err_cnt live in the parent.

Test Plan:
- Reset mid-frame: assert rst_n=0 during a WRITE of 8'h55 to reg 1 -> all registers 0, tx_data=00, busy=0. After release, further rx_valid in that same frame are ignored.
- Write burst: frame {8'h00, 8'h3C, 8'h11, 8'h22} -> reg0=3C (led_out=3C one cycle after the byte), reg1=11, reg2=22, busy falls 1 cycle after frame_active drops.
- Read burst with wrap: pre-load reg14=8'h77; frame {8'h8E, dummy, dummy} -> tx_data = 77 after the cmd byte, then A5 (ID), then reg0.
- Read-only and wrap on write: frame {8'h0F, 8'h99, 8'hAA} -> reg15 still reads A5, reg0 = AA, err_cnt unchanged.
- Bad address: frame {8'h20, 8'h12} with NUM_REGS=16 -> tx_data=FF until frame end, no register change, err_cnt=1. 256 such frames -> err_cnt holds FF.
- Simultaneous end: rx_valid of data byte 8'h5A in the same cycle frame_active falls (WRITE at addr 3) -> reg3=5A, next state IDLE.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared state encoding and protocol constants for the SPI command register file.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WRITE,
        READ,
        DISCARD
    } state_t;

    localparam int         CMD_RD_BIT = 7;
    localparam logic [7:0] TX_IDLE    = 8'h00;
    localparam logic [7:0] TX_ERR     = 8'hFF;

endpackage

// File: rtl/spi_cmd_regfile_if.sv
// Byte-level link between the SPI slave byte engine (master side) and the command decoder.
interface spi_cmd_regfile_if;

    logic       frame_active;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [7:0] tx_data;

    modport master (
        output frame_active,
        output rx_valid,
        output rx_data,
        input  tx_data
    );

    modport slave (
        input  frame_active,
        input  rx_valid,
        input  rx_data,
        output tx_data
    );

endinterface

// File: rtl/spi_regfile.sv
// Purpose: NUM_REGS x 8 flop register file; top address is read-only and returns ID_VALUE.
// Latency: write lands on the clock edge, read is combinational.
// Backpressure: none, every write enable is accepted.
module spi_regfile #(
    parameter int          NUM_REGS = 16,
    parameter int          ADDR_W   = 4,
    parameter logic [7:0]  ID_VALUE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata,
    output logic [7:0]        reg0
);

    // The top address has no storage; writes to it simply match no entry.
    logic [7:0] regs [NUM_REGS-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (we) begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                if (waddr == ADDR_W'(i)) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    always_comb begin
        rdata = ID_VALUE;
        for (int i = 0; i < NUM_REGS - 1; i++) begin
            if (raddr == ADDR_W'(i)) begin
                rdata = regs[i];
            end
        end
    end

    assign reg0 = regs[0];

endmodule

// File: rtl/spi_cmd_regfile.sv
// Purpose: decode SPI command frames (cmd byte + data) into register reads/writes with auto-increment.
// Latency: tx_data and register writes update on the edge that consumes rx_valid.
// Backpressure: none, every rx_valid byte is consumed or ignored in the same cycle.
module spi_cmd_regfile
    import spi_pkg::*;
#(
    parameter int          NUM_REGS = 16,
    parameter int          ADDR_W   = 4,
    parameter logic [7:0]  ID_VALUE = 8'hA5
) (
    input  logic                clk,
    input  logic                rst_n,
    spi_cmd_regfile_if.slave    bus,
    output logic [7:0]          led_out,
    output logic                busy,
    output logic [7:0]          err_cnt
);

    state_t            state, state_nxt;
    logic              frame_prev;
    logic [ADDR_W-1:0] addr, addr_nxt, raddr;
    logic [7:0]        tx_q, tx_nxt, rd_data;
    logic              we, err_inc, cmd_bad;

    assign cmd_bad = {1'b0, bus.rx_data[6:0]} >= 8'(NUM_REGS);

    // In CMD the lookup uses the incoming address; in READ it prefetches the next address.
    assign raddr = (state == CMD) ? bus.rx_data[ADDR_W-1:0] : addr + ADDR_W'(1);

    spi_regfile #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .ID_VALUE (ID_VALUE)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .waddr (addr),
        .wdata (bus.rx_data),
        .raddr (raddr),
        .rdata (rd_data),
        .reg0  (led_out)
    );

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        tx_nxt    = tx_q;
        we        = 1'b0;
        err_inc   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.frame_active && !frame_prev) begin
                    state_nxt = CMD;
                end
            end
            CMD: begin
                if (bus.rx_valid) begin
                    if (cmd_bad) begin
                        state_nxt = DISCARD;
                        err_inc   = 1'b1;
                        tx_nxt    = TX_ERR;
                    end else begin
                        addr_nxt = bus.rx_data[ADDR_W-1:0];
                        if (bus.rx_data[CMD_RD_BIT]) begin
                            state_nxt = READ;
                            tx_nxt    = rd_data;
                        end else begin
                            state_nxt = WRITE;
                            tx_nxt    = TX_IDLE;
                        end
                    end
                end
            end
            WRITE: begin
                if (bus.rx_valid) begin
                    we       = 1'b1;
                    addr_nxt = addr + ADDR_W'(1);
                end
            end
            READ: begin
                if (bus.rx_valid) begin
                    addr_nxt = addr + ADDR_W'(1);
                    tx_nxt   = rd_data;
                end
            end
            DISCARD: begin
                tx_nxt = TX_ERR;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // The byte above is still processed when the frame closes in the same cycle.
        if (state != IDLE && !bus.frame_active) begin
            state_nxt = IDLE;
            tx_nxt    = TX_IDLE;
        end
    end

    // frame_prev resets high so a frame already open at reset release is never decoded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            frame_prev <= 1'b1;
            addr       <= '0;
            tx_q       <= TX_IDLE;
            err_cnt    <= 8'h00;
        end else begin
            state      <= state_nxt;
            frame_prev <= bus.frame_active;
            addr       <= addr_nxt;
            tx_q       <= tx_nxt;
            if (err_inc && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'h01;
            end
        end
    end

    assign bus.tx_data = tx_q;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_spi_cmd_regfile.sv
// Directed and randomized frames for spi_cmd_regfile, checked against a frame-level protocol model.
module tb_spi_cmd_regfile;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] led_out;
    logic [7:0] err_cnt;
    logic       busy;

    always #5 clk = ~clk;

    spi_cmd_regfile_if bus ();

    spi_cmd_regfile #(
        .NUM_REGS (16),
        .ADDR_W   (4),
        .ID_VALUE (8'hA5)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .led_out (led_out),
        .busy    (busy),
        .err_cnt (err_cnt)
    );

    int         tests = 0;
    int         fails = 0;
    logic [7:0] m_regs [16];
    int         m_err;
    logic [7:0] fb [0:19];
    int         fn;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_rd(input int a);
        return (a == 15) ? 8'hA5 : m_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_err = 0;
    endtask

    // Plays fb[0..fn-1] as one frame and checks every byte against the protocol rules.
    task automatic run_frame(input bit end_with_last);
        int         a;
        bit         rd;
        bit         bad;
        logic [7:0] exp_tx;
        a = 0; rd = 1'b0; bad = 1'b0; exp_tx = 8'h00;
        @(posedge clk); #1 bus.frame_active = 1'b1;
        @(posedge clk); #1;
        check("cmd_wait_tx", bus.tx_data, 8'h00);
        check("cmd_wait_busy", {7'd0, busy}, 8'h01);
        for (int i = 0; i < fn; i++) begin
            bit last_end;
            last_end = end_with_last && (i == fn - 1);
            bus.rx_valid = 1'b1;
            bus.rx_data  = fb[i];
            if (last_end) bus.frame_active = 1'b0;
            @(posedge clk); #1 bus.rx_valid = 1'b0;
            if (i == 0) begin
                bad = (fb[0][6:0] >= 7'd16);
                rd  = fb[0][7];
                a   = int'(fb[0][3:0]);
                if (bad) begin
                    if (m_err < 255) m_err++;
                    exp_tx = 8'hFF;
                end else begin
                    exp_tx = rd ? m_rd(a) : 8'h00;
                end
            end else if (bad) begin
                exp_tx = 8'hFF;
            end else if (rd) begin
                a      = (a + 1) % 16;
                exp_tx = m_rd(a);
            end else begin
                if (a != 15) m_regs[a] = fb[i];
                a      = (a + 1) % 16;
                exp_tx = 8'h00;
            end
            if (last_end) exp_tx = 8'h00;
            check("byte_tx", bus.tx_data, exp_tx);
            check("byte_led", led_out, m_regs[0]);
            check("byte_busy", {7'd0, busy}, last_end ? 8'h00 : 8'h01);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        if (!end_with_last || fn == 0) begin
            bus.frame_active = 1'b0;
            check("busy_before_edge", {7'd0, busy}, 8'h01);
            @(posedge clk); #1;
        end
        check("end_busy", {7'd0, busy}, 8'h00);
        check("end_tx", bus.tx_data, 8'h00);
        check("end_err", err_cnt, 8'(m_err));
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.frame_active = 1'b0;
        bus.rx_valid     = 1'b0;
        bus.rx_data      = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", bus.tx_data, 8'h00);
        check("rst_led", led_out, 8'h00);
        check("rst_busy", {7'd0, busy}, 8'h00);
        check("rst_err", err_cnt, 8'h00);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Populate reg0/reg1 so the mid-frame reset has something to clear.
        fb[0] = 8'h00; fb[1] = 8'hC3; fb[2] = 8'h99; fn = 3;
        run_frame(1'b0);

        // Reset during a WRITE of 8'h55 to reg 1.
        @(posedge clk); #1 bus.frame_active = 1'b1;
        @(posedge clk); #1 bus.rx_valid = 1'b1; bus.rx_data = 8'h01;
        @(posedge clk); #1 bus.rx_valid = 1'b1; bus.rx_data = 8'h55;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_tx", bus.tx_data, 8'h00);
        check("midrst_led", led_out, 8'h00);
        check("midrst_busy", {7'd0, busy}, 8'h00);
        bus.rx_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = (i == 0) ? 8'h00 : 8'hEE;
            @(posedge clk); #1 bus.rx_valid = 1'b0;
            check("postrst_busy", {7'd0, busy}, 8'h00);
            check("postrst_led", led_out, 8'h00);
        end
        @(posedge clk); #1 bus.frame_active = 1'b0;
        @(posedge clk); #1;
        fb[0] = 8'h80; fb[1] = 8'h00; fn = 2;
        run_frame(1'b0);

        // Empty frame is not an error.
        fn = 0;
        run_frame(1'b0);

        // Write burst.
        fb[0] = 8'h00; fb[1] = 8'h3C; fb[2] = 8'h11; fb[3] = 8'h22; fn = 4;
        run_frame(1'b0);

        // Read burst with wrap through the ID address.
        fb[0] = 8'h0E; fb[1] = 8'h77; fn = 2;
        run_frame(1'b0);
        fb[0] = 8'h8E; fb[1] = 8'h00; fb[2] = 8'h00; fn = 3;
        run_frame(1'b0);

        // Read-only top register and write wrap.
        fb[0] = 8'h0F; fb[1] = 8'h99; fb[2] = 8'hAA; fn = 3;
        run_frame(1'b0);
        fb[0] = 8'h8F; fb[1] = 8'h00; fn = 2;
        run_frame(1'b0);

        // Bad address, then saturation of the error counter.
        fb[0] = 8'h20; fb[1] = 8'h12; fn = 2;
        run_frame(1'b0);
        for (int k = 0; k < 256; k++) begin
            fb[0] = {1'($urandom), 7'($urandom_range(16, 127))};
            fb[1] = 8'($urandom);
            fn    = 1 + (k % 2);
            run_frame(1'b0);
        end
        check("err_saturated", err_cnt, 8'hFF);

        // Data byte coincident with frame end.
        fb[0] = 8'h03; fb[1] = 8'h5A; fn = 2;
        run_frame(1'b1);
        fb[0] = 8'h83; fb[1] = 8'h00; fn = 2;
        run_frame(1'b0);

        // Random frames.
        for (int k = 0; k < 40; k++) begin
            fn = $urandom_range(1, 6);
            if ($urandom_range(0, 7) == 0) fb[0] = 8'($urandom);
            else fb[0] = {1'($urandom), 3'b000, 4'($urandom)};
            for (int j = 1; j < fn; j++) fb[j] = 8'($urandom);
            run_frame($urandom_range(0, 3) == 0);
        end

        // Full readback wrapping through every address.
        fb[0] = 8'h80;
        for (int j = 1; j < 17; j++) fb[j] = 8'h00;
        fn = 17;
        run_frame(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
